// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants, scanner state type and helper functions for
// the parametrised register file (clog2, popcount, saturating add).
package regfile_pkg;

    localparam int unsigned XLEN_DEFAULT  = 32;
    localparam int unsigned NREGS_DEFAULT = 32;
    localparam int unsigned MAX_NREAD     = 4;

    // The usage scanner has a single sweeping state.
    typedef enum logic {SCAN = 1'b0} scan_state_t;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int unsigned popcount(input logic [MAX_NREAD-1:0] v);
        int unsigned c;
        c = 0;
        for (int unsigned i = 0; i < MAX_NREAD; i++) begin
            c = c + {31'd0, v[i]};
        end
        return c;
    endfunction

    // Adds b to a and clamps to 2^width-1; callers truncate to width.
    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input int unsigned width);
        logic [63:0] maxv;
        logic [63:0] sum;
        maxv = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        sum  = a + b;
        if ((sum < a) || (sum > maxv)) begin
            return maxv;
        end
        return sum;
    endfunction

endpackage

// File: rtl/regfile_param_if.sv
// regfile_param_if: read/write bus of the register file.
//   rdEn/rdAddr/rdData : NREAD packed read ports (port p at [p*W +: W])
//   enWrite/wrAddr/wrData : single write port
// master drives addresses/write data, slave (the register file) returns rdData.
interface regfile_param_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREAD = 2,
    parameter int unsigned AW    = 5
);
    logic [NREAD-1:0]      rdEn;
    logic [NREAD*AW-1:0]   rdAddr;
    logic [NREAD*XLEN-1:0] rdData;
    logic                  enWrite;
    logic [AW-1:0]         wrAddr;
    logic [XLEN-1:0]       wrData;

    modport master (output rdEn, rdAddr, enWrite, wrAddr, wrData,
                    input  rdData);
    modport slave  (input  rdEn, rdAddr, enWrite, wrAddr, wrData,
                    output rdData);
endinterface

// File: rtl/regfile_usage_scan.sv
// regfile_usage_scan: sweeps per-register access counters 1..NREGS-1, one per
// cycle, and publishes the most-read register at the end of every sweep.
//   clk, reset       : clock, synchronous active-high reset
//   clearStats       : restart sweep and zero published result
//   accessCounts     : flattened counters, register r at [r*CNTW +: CNTW]
//   regMostUsed/Count: result of the last completed sweep
module regfile_usage_scan
    import regfile_pkg::*;
#(
    parameter int unsigned NREGS = 32,
    parameter int unsigned CNTW  = 32,
    parameter int unsigned AW    = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clearStats,
    input  logic [NREGS*CNTW-1:0] accessCounts,
    output logic [AW-1:0]         regMostUsed,
    output logic [CNTW-1:0]       regMostUsedCount
);

    scan_state_t     state, state_next;
    logic [AW-1:0]   scan_idx, scan_idx_next;
    logic [AW-1:0]   best_idx, best_idx_next;
    logic [CNTW-1:0] best_cnt, best_cnt_next;
    logic [AW-1:0]   most_idx_next;
    logic [CNTW-1:0] most_cnt_next;
    logic [AW-1:0]   cand_idx;
    logic [CNTW-1:0] cand_cnt;
    logic [CNTW-1:0] cur_cnt;

    always_comb begin
        state_next    = state;
        scan_idx_next = scan_idx;
        best_idx_next = best_idx;
        best_cnt_next = best_cnt;
        most_idx_next = regMostUsed;
        most_cnt_next = regMostUsedCount;
        cur_cnt       = accessCounts[scan_idx*CNTW +: CNTW];
        cand_idx      = best_idx;
        cand_cnt      = best_cnt;
        case (state)
            SCAN: begin
                // Strictly greater: ties keep the earlier (lower) index.
                if (cur_cnt > best_cnt) begin
                    cand_idx = scan_idx;
                    cand_cnt = cur_cnt;
                end
                if (scan_idx == AW'(NREGS - 1)) begin
                    most_idx_next = cand_idx;
                    most_cnt_next = cand_cnt;
                    best_idx_next = '0;
                    best_cnt_next = '0;
                    scan_idx_next = AW'(1);
                end else begin
                    best_idx_next = cand_idx;
                    best_cnt_next = cand_cnt;
                    scan_idx_next = scan_idx + 1'b1;
                end
            end
            default: state_next = SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || clearStats) begin
            state            <= SCAN;
            scan_idx         <= AW'(1);
            best_idx         <= '0;
            best_cnt         <= '0;
            regMostUsed      <= '0;
            regMostUsedCount <= '0;
        end else begin
            state            <= state_next;
            scan_idx         <= scan_idx_next;
            best_idx         <= best_idx_next;
            best_cnt         <= best_cnt_next;
            regMostUsed      <= most_idx_next;
            regMostUsedCount <= most_cnt_next;
        end
    end

endmodule

// File: rtl/regfile_param.sv
// regfile_param: multi-port integer register file (x0 hardwired to zero) with
// optional write-to-read bypass, saturating usage statistics and a most-used
// register scanner.
//   clk, reset       : clock, synchronous active-high reset
//   bus (slave)      : rdEn/rdAddr/rdData read ports, enWrite/wrAddr/wrData
//   clearStats       : zero all statistics (register contents kept)
//   regAccessCount   : total counted reads
//   regWriteCount    : total committed writes
//   regMostUsed/Count: most-read register from the last completed sweep
//   powerActive      : registered activity flag
module regfile_param
    import regfile_pkg::*;
#(
    parameter  int unsigned XLEN   = XLEN_DEFAULT,
    parameter  int unsigned NREGS  = NREGS_DEFAULT,
    parameter  int unsigned NREAD  = 2,
    parameter  int unsigned CNTW   = 32,
    parameter  int unsigned BYPASS = 1,
    localparam int unsigned AW     = clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_param_if.slave       bus,
    input  logic                 clearStats,
    output logic [CNTW-1:0]      regAccessCount,
    output logic [CNTW-1:0]      regWriteCount,
    output logic [AW-1:0]        regMostUsed,
    output logic [CNTW-1:0]      regMostUsedCount,
    output logic                 powerActive
);

    logic [XLEN-1:0]       regs     [NREGS];
    logic [CNTW-1:0]       acc_cnt  [NREGS];
    logic [CNTW-1:0]       acc_next [NREGS];
    logic [AW-1:0]         rd_addr  [NREAD];
    logic [NREAD-1:0]      rd_count;
    logic                  wr_commit;
    logic [CNTW-1:0]       access_next;
    logic [CNTW-1:0]       write_next;
    logic [NREGS*CNTW-1:0] acc_flat;

    always_comb begin
        bus.rdData = '0;
        for (int unsigned p = 0; p < NREAD; p++) begin
            rd_addr[p] = bus.rdAddr[p*AW +: AW];
            if (rd_addr[p] == '0) begin
                bus.rdData[p*XLEN +: XLEN] = '0;
            end else if ((BYPASS != 0) && wr_commit && (rd_addr[p] == bus.wrAddr)) begin
                bus.rdData[p*XLEN +: XLEN] = bus.wrData;
            end else begin
                bus.rdData[p*XLEN +: XLEN] = regs[rd_addr[p]];
            end
        end
    end

    always_comb begin
        int unsigned inc;
        inc       = 0;
        wr_commit = bus.enWrite && (bus.wrAddr != '0);
        for (int unsigned p = 0; p < NREAD; p++) begin
            rd_count[p] = bus.rdEn[p] && (bus.rdAddr[p*AW +: AW] != '0);
        end
        // Each register gains the number of counting ports aimed at it.
        for (int unsigned a = 0; a < NREGS; a++) begin
            inc = 0;
            for (int unsigned p = 0; p < NREAD; p++) begin
                if (rd_count[p] && (bus.rdAddr[p*AW +: AW] == AW'(a))) begin
                    inc = inc + 1;
                end
            end
            acc_next[a] = CNTW'(sat_add(64'(acc_cnt[a]), 64'(inc), CNTW));
        end
        access_next = CNTW'(sat_add(64'(regAccessCount),
                                    64'(popcount(MAX_NREAD'(rd_count))), CNTW));
        write_next  = CNTW'(sat_add(64'(regWriteCount), 64'(wr_commit), CNTW));
    end

    always_comb begin
        acc_flat = '0;
        for (int unsigned a = 0; a < NREGS; a++) begin
            acc_flat[a*CNTW +: CNTW] = acc_cnt[a];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned a = 0; a < NREGS; a++) begin
                regs[a]    <= '0;
                acc_cnt[a] <= '0;
            end
            regAccessCount <= '0;
            regWriteCount  <= '0;
            powerActive    <= 1'b0;
        end else begin
            if (wr_commit) begin
                regs[bus.wrAddr] <= bus.wrData;
            end
            // A clear cycle still commits its write but counts nothing.
            if (clearStats) begin
                for (int unsigned a = 0; a < NREGS; a++) begin
                    acc_cnt[a] <= '0;
                end
                regAccessCount <= '0;
                regWriteCount  <= '0;
                powerActive    <= 1'b0;
            end else begin
                for (int unsigned a = 0; a < NREGS; a++) begin
                    acc_cnt[a] <= acc_next[a];
                end
                regAccessCount <= access_next;
                regWriteCount  <= write_next;
                powerActive    <= wr_commit || (|rd_count);
            end
        end
    end

    regfile_usage_scan #(
        .NREGS (NREGS),
        .CNTW  (CNTW),
        .AW    (AW)
    ) u_scan (
        .clk              (clk),
        .reset            (reset),
        .clearStats       (clearStats),
        .accessCounts     (acc_flat),
        .regMostUsed      (regMostUsed),
        .regMostUsedCount (regMostUsedCount)
    );

endmodule
